// File: rtl/q_bcd_sseg_scan_pkg.sv
// q_sseg_pkg
// Shared definitions for the BCD seven-segment scan block: the conversion
// FSM state type, digit geometry and the segment codes (active-high, gfedcba
// in bits [6:0], dp in bit 7 and always 0).
// Ports: none (package).

package q_sseg_pkg;

    localparam int NIBBLE_W    = 4;
    localparam int DIGIT_COUNT = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] SEG_0     = 8'h3F;
    localparam logic [7:0] SEG_1     = 8'h06;
    localparam logic [7:0] SEG_2     = 8'h5B;
    localparam logic [7:0] SEG_3     = 8'h4F;
    localparam logic [7:0] SEG_4     = 8'h66;
    localparam logic [7:0] SEG_5     = 8'h6D;
    localparam logic [7:0] SEG_6     = 8'h7D;
    localparam logic [7:0] SEG_7     = 8'h07;
    localparam logic [7:0] SEG_8     = 8'h7F;
    localparam logic [7:0] SEG_9     = 8'h6F;
    localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/q_bcd_sseg_scan_if.sv
// q_bcd_sseg_scan_if
// Bundles the data/strobe input and the display outputs of q_bcd_sseg_scan.
// Ports (signals):
//   Q       [7:0]  value from the shift register
//   upd            update strobe
//   busy           conversion in flight
//   An      [2:0]  one-hot digit select (0 = ones, 1 = tens, 2 = hundreds)
//   Seg_Out [7:0]  segment pattern, active-high, dp in bit 7
// Modports: master drives Q/upd, slave (the display block) drives the rest.

interface q_bcd_sseg_scan_if;

    logic [7:0] Q;
    logic       upd;
    logic       busy;
    logic [2:0] An;
    logic [7:0] Seg_Out;

    modport master (
        output Q,
        output upd,
        input  busy,
        input  An,
        input  Seg_Out
    );

    modport slave (
        input  Q,
        input  upd,
        output busy,
        output An,
        output Seg_Out
    );

endinterface

// File: rtl/q_bcd_sseg_scan_decode.sv
// sseg_decode
// Purely combinational BCD nibble to seven-segment pattern decode.
// Ports:
//   nibble [3:0]  BCD digit; values 10..15 decode to blank
//   seg    [7:0]  active-high segments, gfedcba in [6:0], dp (bit 7) = 0

module sseg_decode
    import q_sseg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [7:0]          seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/q_bcd_sseg_scan.sv
// q_bcd_sseg_scan
// Samples the shift register output Q on an upd strobe, converts it to three
// BCD digits with a one-bit-per-cycle double-dabble engine, commits the digits
// only once the conversion is complete, and scans them onto a shared
// seven-segment bus with a one-hot ring-counter anode.
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays selected (>= 1)
// Ports:
//   clk  system clock (rising edge)
//   rst  synchronous active-high reset
//   bus  q_bcd_sseg_scan_if.slave (Q, upd in; busy, An, Seg_Out out)
// Configuration macro:
//   LEADING_ZERO_BLANK_EN  blank leading zero hundreds/tens digits

module q_bcd_sseg_scan
    import q_sseg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input logic              clk,
    input logic              rst,
    q_bcd_sseg_scan_if.slave bus
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

    state_t        state;
    logic [2:0]    iter;
    // {hundreds, tens, ones, binary} working register
    logic [19:0]   sreg;
    logic [19:0]   adj;
    logic [NIBBLE_W-1:0] dig_h;
    logic [NIBBLE_W-1:0] dig_t;
    logic [NIBBLE_W-1:0] dig_o;

    logic [CNT_W-1:0] rcnt;
    logic [2:0]       an;

    logic [NIBBLE_W-1:0] sel_digit;
    logic                blank;
    logic [7:0]          dec_seg;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift,
    // so that the shift carries it correctly into the next decade.
    always_comb begin
        adj = sreg;
        if (sreg[19:16] >= 4'd5) adj[19:16] = sreg[19:16] + 4'd3;
        if (sreg[15:12] >= 4'd5) adj[15:12] = sreg[15:12] + 4'd3;
        if (sreg[11:8]  >= 4'd5) adj[11:8]  = sreg[11:8]  + 4'd3;
    end

    // Conversion FSM. Digits are committed only in DONE so the display never
    // shows a half-converted value; upd outside IDLE is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            iter  <= 3'd0;
            sreg  <= 20'd0;
            dig_h <= '0;
            dig_t <= '0;
            dig_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.upd) begin
                        sreg  <= {12'd0, bus.Q};
                        iter  <= 3'd0;
                        state <= CONV;
                    end
                end
                CONV: begin
                    sreg <= adj << 1;
                    iter <= iter + 3'd1;
                    if (iter == 3'd7) state <= DONE;
                end
                DONE: begin
                    dig_h <= sreg[19:16];
                    dig_t <= sreg[15:12];
                    dig_o <= sreg[11:8];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);

    // Refresh divider and anode ring; free-running regardless of FSM state.
    always_ff @(posedge clk) begin
        if (rst) begin
            rcnt <= '0;
            an   <= 3'b001;
        end else if (rcnt == CNT_MAX) begin
            rcnt <= '0;
            an   <= {an[1:0], an[2]};
        end else begin
            rcnt <= rcnt + CNT_W'(1);
        end
    end

    assign bus.An = an;

    // Select the committed digit under the active anode and decide blanking.
    always_comb begin
        sel_digit = dig_o;
        blank     = 1'b0;
        case (an)
            3'b010:  sel_digit = dig_t;
            3'b100:  sel_digit = dig_h;
            default: sel_digit = dig_o;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (an == 3'b100 && dig_h == '0) blank = 1'b1;
        if (an == 3'b010 && dig_h == '0 && dig_t == '0) blank = 1'b1;
`endif
    end

    sseg_decode u_decode (
        .nibble (sel_digit),
        .seg    (dec_seg)
    );

    assign bus.Seg_Out = blank ? SEG_BLANK : {1'b0, dec_seg[6:0]};

endmodule

// File: tb/tb_q_bcd_sseg_scan.sv
// tb_q_bcd_sseg_scan
// Self-checking bench for q_bcd_sseg_scan with REFRESH_DIV = 4. A behavioural
// model tracks the displayed value, the conversion busy window and the scan
// position; every cycle after reset the DUT outputs are compared to it.
// Directed sequences pin the model with hand-computed segment codes.
// Honours LEADING_ZERO_BLANK_EN for the expected blanking.

module tb_q_bcd_sseg_scan;

    localparam int N = 4;

`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LEAD_ZERO = 8'h00;
    localparam bit BLANK_ON = 1'b1;
`else
    localparam logic [7:0] LEAD_ZERO = 8'h3F;
    localparam bit BLANK_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    q_bcd_sseg_scan_if bus ();

    q_bcd_sseg_scan #(.REFRESH_DIV(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0] segTable [10] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66,
                                  8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F};

    // Model state: shown value, value being converted, cycles of busy left,
    // edges since the last reset.
    int modelVal     = 0;
    int modelLatched = 0;
    int modelLeft    = 0;
    int modelTick    = 0;
    bit modelValid   = 1'b0;

    // The display updates 9 edges after the accepting edge; busy covers that
    // whole window and a strobe is only accepted when nothing is in flight.
    always @(posedge clk) begin
        if (rst) begin
            modelVal   = 0;
            modelLeft  = 0;
            modelTick  = 0;
            modelValid = 1'b1;
        end else if (modelValid) begin
            modelTick = modelTick + 1;
            if (modelLeft == 0) begin
                if (bus.upd) begin
                    modelLatched = int'(bus.Q);
                    modelLeft    = 9;
                end
            end else begin
                modelLeft = modelLeft - 1;
                if (modelLeft == 0) modelVal = modelLatched;
            end
        end
    end

    function automatic int scanIndex();
        return (modelTick / N) % 3;
    endfunction

    function automatic logic [2:0] expectedAn();
        case (scanIndex())
            0:       return 3'b001;
            1:       return 3'b010;
            default: return 3'b100;
        endcase
    endfunction

    function automatic logic [7:0] expectedSeg();
        int idx;
        int digit;
        idx = scanIndex();
        if (idx == 0)      digit = modelVal % 10;
        else if (idx == 1) digit = (modelVal / 10) % 10;
        else               digit = modelVal / 100;
        if (BLANK_ON && idx == 2 && modelVal < 100) return 8'h00;
        if (BLANK_ON && idx == 1 && modelVal < 10)  return 8'h00;
        return segTable[digit];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                      name, actual, expected, $time);
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (modelValid) begin
            checkOutput("busy", {31'd0, bus.busy}, {31'd0, modelLeft != 0});
            checkOutput("an", {29'd0, bus.An}, {29'd0, expectedAn()});
            checkOutput("seg", {24'd0, bus.Seg_Out}, {24'd0, expectedSeg()});
        end
    end

    task automatic applyStimulus(input logic r, input logic u, input logic [7:0] q);
        @(posedge clk);
        #1;
        rst     = r;
        bus.upd = u;
        bus.Q   = q;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while (bus.busy && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic checkSegAt(input string name, input logic [2:0] anTarget,
                              input logic [7:0] expected);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.An !== anTarget && n < 3 * N + 2) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_an"}, {29'd0, bus.An}, {29'd0, anTarget});
        checkOutput(name, {24'd0, bus.Seg_Out}, {24'd0, expected});
    endtask

    logic [2:0] anSeq [13] = '{3'b001, 3'b001, 3'b001, 3'b001,
                               3'b010, 3'b010, 3'b010, 3'b010,
                               3'b100, 3'b100, 3'b100, 3'b100, 3'b001};

    initial begin
        int busyCycles;
        logic r;
        logic u;
        logic [7:0] q;

        rst     = 1'b1;
        bus.upd = 1'b0;
        bus.Q   = 8'd0;

        // Reset held for two edges, then scan rotation from reset
        applyStimulus(1'b1, 1'b0, 8'd0);
        applyStimulus(1'b1, 1'b0, 8'd0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        @(negedge clk);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_seg", {24'd0, bus.Seg_Out}, 32'h3F);
        checkOutput("an_seq", {29'd0, bus.An}, {29'd0, anSeq[0]});
        for (int i = 1; i < 13; i++) begin
            @(negedge clk);
            checkOutput("an_seq", {29'd0, bus.An}, {29'd0, anSeq[i]});
        end

        // Q = 7: busy for 9 cycles, then 0,0,7
        applyStimulus(1'b0, 1'b1, 8'd7);
        applyStimulus(1'b0, 1'b0, 8'd7);
        busyCycles = 0;
        @(negedge clk);
        while (bus.busy && busyCycles < 20) begin
            busyCycles++;
            @(negedge clk);
        end
        checkOutput("busy_len", busyCycles, 32'd9);
        checkSegAt("q7_ones", 3'b001, 8'h07);
        checkSegAt("q7_tens", 3'b010, LEAD_ZERO);
        checkSegAt("q7_hund", 3'b100, LEAD_ZERO);

        // Q = 255
        applyStimulus(1'b0, 1'b1, 8'd255);
        applyStimulus(1'b0, 1'b0, 8'd0);
        waitIdle();
        checkSegAt("q255_ones", 3'b001, 8'h6D);
        checkSegAt("q255_tens", 3'b010, 8'h6D);
        checkSegAt("q255_hund", 3'b100, 8'h5B);

        // Strobe during conversion is dropped; strobe at E+10 is taken
        applyStimulus(1'b0, 1'b1, 8'd7);
        applyStimulus(1'b0, 1'b0, 8'd7);
        applyStimulus(1'b0, 1'b1, 8'd200);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b0, 8'd200);
        applyStimulus(1'b0, 1'b1, 8'd200);
        @(negedge clk);
        checkOutput("ignored_model", modelVal, 32'd7);
        checkOutput("ignored_busy", {31'd0, bus.busy}, 32'd0);
        applyStimulus(1'b0, 1'b0, 8'd0);
        waitIdle();
        checkSegAt("q200_ones", 3'b001, 8'h3F);
        checkSegAt("q200_tens", 3'b010, 8'h3F);
        checkSegAt("q200_hund", 3'b100, 8'h5B);

        // Reset at E+4 during conversion of 99
        applyStimulus(1'b0, 1'b1, 8'd99);
        applyStimulus(1'b0, 1'b0, 8'd99);
        applyStimulus(1'b0, 1'b0, 8'd99);
        applyStimulus(1'b0, 1'b0, 8'd99);
        applyStimulus(1'b1, 1'b0, 8'd99);
        applyStimulus(1'b0, 1'b0, 8'd0);
        @(negedge clk);
        checkOutput("abort_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("abort_model", modelVal, 32'd0);
        repeat (12) applyStimulus(1'b0, 1'b0, 8'd0);
        checkSegAt("abort_ones", 3'b001, 8'h3F);

        // Reset and strobe together: nothing latched
        applyStimulus(1'b1, 1'b1, 8'd123);
        applyStimulus(1'b0, 1'b0, 8'd0);
        @(negedge clk);
        checkOutput("rst_upd_busy", {31'd0, bus.busy}, 32'd0);

        // Randomized traffic checked by the per-cycle model comparison
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 79) == 0);
            u = ($urandom_range(0, 3) == 0);
            q = 8'($urandom_range(0, 255));
            applyStimulus(r, u, q);
        end
        applyStimulus(1'b0, 1'b0, 8'd0);
        waitIdle();
        repeat (15) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
